// File: rtl/delay_cal_pkg.sv
// rtl/delay_cal_pkg.sv - shared types and defaults for the calibration burst generator
// Purpose: state encoding, default widths and configuration record for delay_cal_burst.
// Contents: DEF_WORD_W / DEF_CNT_W defaults, burst_state_t, cfg_t.
package delay_cal_pkg;

  localparam int DEF_WORD_W = 256;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } burst_state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] delay;
    logic [DEF_CNT_W-1:0] width;
    logic [DEF_CNT_W-1:0] gap;
    logic [DEF_CNT_W-1:0] count;
  } cfg_t;

endpackage

// File: rtl/delay_cal_dncnt.sv
// rtl/delay_cal_dncnt.sv - loadable down-counter with zero flag
// Purpose: counts a loaded value down to zero and holds there.
// Ports: clk, rst (async, active-high), load/load_val (load wins over en),
//        en (decrement when nonzero), zero (count == 0).
module delay_cal_dncnt
  import delay_cal_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/delay_cal_burst.sv
// rtl/delay_cal_burst.sv - programmable calibration-pattern burst generator
// Purpose: on an armed trigger, wait D cycles, then emit the captured word for W cycles,
//          N times, with G zero cycles between pulses; zero otherwise.
// Ports: clk, rst (async, active-high), trig (level, one burst per high level),
//        abort (ends a running burst), static_word and cfg_delay/width/gap/count
//        (captured at acceptance), word_out/busy/done (registered outputs).
module delay_cal_burst
  import delay_cal_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              abort,
  input  logic [WORD_W-1:0] static_word,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [WORD_W-1:0] word_out,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_DELAY = DELAY;
  localparam logic [2:0] S_PULSE = PULSE;
  localparam logic [2:0] S_GAP   = GAP;
  localparam logic [2:0] S_FIN   = FIN;

  localparam logic [CNT_W-1:0] ONE = 1;

  // Width and count of 0 behave as 1, so their reload value saturates at 0.
  function automatic logic [CNT_W-1:0] minus1_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  logic [2:0]        state, state_nxt;
  logic              armed, accept;
  logic [WORD_W-1:0] word_q, word_nxt;
  logic [CNT_W-1:0]  width_q, gap_q, count_q, idx_q;
  logic              idx_clr, idx_inc, last_pulse;
  logic              d_load, d_en, d_zero;
  logic              w_load, w_en, w_zero;
  logic              g_load, g_en, g_zero;
  logic [CNT_W-1:0]  w_load_val;

  // At acceptance the latched copies are not yet valid, so the first width load
  // comes straight from the input port.
  assign w_load_val = minus1_sat((state == S_IDLE) ? cfg_width : width_q);
  assign last_pulse = (idx_q == minus1_sat(count_q));

  delay_cal_dncnt #(.CNT_W(CNT_W)) u_delay_cnt (
    .clk(clk), .rst(rst), .load(d_load), .en(d_en),
    .load_val(cfg_delay - ONE), .zero(d_zero)
  );

  delay_cal_dncnt #(.CNT_W(CNT_W)) u_width_cnt (
    .clk(clk), .rst(rst), .load(w_load), .en(w_en),
    .load_val(w_load_val), .zero(w_zero)
  );

  delay_cal_dncnt #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .load(g_load), .en(g_en),
    .load_val(gap_q - ONE), .zero(g_zero)
  );

  always_comb begin
    state_nxt = state;
    word_nxt  = '0;
    accept    = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    d_load    = 1'b0;
    d_en      = 1'b0;
    w_load    = 1'b0;
    w_en      = 1'b0;
    g_load    = 1'b0;
    g_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && trig) begin
          accept  = 1'b1;
          idx_clr = 1'b1;
          if (cfg_delay == '0) begin
            state_nxt = S_PULSE;
            w_load    = 1'b1;
            word_nxt  = static_word;
          end else begin
            state_nxt = S_DELAY;
            d_load    = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (abort) begin
          state_nxt = S_FIN;
        end else if (d_zero) begin
          state_nxt = S_PULSE;
          w_load    = 1'b1;
          word_nxt  = word_q;
        end else begin
          d_en = 1'b1;
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_nxt = S_FIN;
        end else if (!w_zero) begin
          w_en     = 1'b1;
          word_nxt = word_q;
        end else if (last_pulse) begin
          state_nxt = S_FIN;
        end else if (gap_q == '0) begin
          // Back-to-back: start the next pulse without leaving PULSE.
          w_load   = 1'b1;
          idx_inc  = 1'b1;
          word_nxt = word_q;
        end else begin
          state_nxt = S_GAP;
          g_load    = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt = S_FIN;
        end else if (g_zero) begin
          state_nxt = S_PULSE;
          w_load    = 1'b1;
          idx_inc   = 1'b1;
          word_nxt  = word_q;
        end else begin
          g_en = 1'b1;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      word_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      armed    <= 1'b1;
      word_q   <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
    end else begin
      state    <= state_nxt;
      word_out <= word_nxt;
      busy     <= (state_nxt == S_DELAY) || (state_nxt == S_PULSE) || (state_nxt == S_GAP);
      done     <= (state_nxt == S_FIN);
      if (accept) begin
        armed   <= 1'b0;
        word_q  <= static_word;
        width_q <= cfg_width;
        gap_q   <= cfg_gap;
        count_q <= cfg_count;
      end else if (state == S_IDLE && !trig) begin
        armed <= 1'b1;
      end
      if (idx_clr) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + ONE;
      end
    end
  end

endmodule
